// File: rtl/d_term_pkg.sv
// Shared defaults and helpers for the PID derivative-term datapath.
package d_term_pkg;

    localparam int D_ERR_W    = 10;
    localparam int D_DIFF_W   = 7;
    localparam int D_COEFF_W  = 6;
    localparam int D_LAG_DFLT = 2;
    localparam logic [5:0] D_COEFF_DFLT = 6'h0B;

    // Clamped value together with a flag that says whether clamping happened.
    typedef struct packed {
        logic signed [31:0] value;
        logic               sat;
    } sat_res_t;

    // Clamp a signed value into the range of a signed number of 'width' bits.
    function automatic sat_res_t sat_signed(input logic signed [31:0] value, input int width);
        sat_res_t           res;
        logic signed [31:0] max_v;
        logic signed [31:0] min_v;
        max_v = (32'sd1 <<< (width - 1)) - 32'sd1;
        min_v = -(32'sd1 <<< (width - 1));
        if (value > max_v) begin
            res.value = max_v;
            res.sat   = 1'b1;
        end else if (value < min_v) begin
            res.value = min_v;
            res.sat   = 1'b1;
        end else begin
            res.value = value;
            res.sat   = 1'b0;
        end
        return res;
    endfunction

endpackage

// File: rtl/d_hist_shift.sv
// History of the last LAG accepted error samples; shifts only on enable.
// 'last' is the oldest stored sample (LAG enables ago).
module d_hist_shift #(
    parameter int ERR_W = 10,
    parameter int LAG   = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic [ERR_W-1:0] din,
    output logic [ERR_W-1:0] last
);

    logic [ERR_W-1:0] hist_r [LAG];

    // Shift register: clear has priority over an accepted sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < LAG; k++) hist_r[k] <= '0;
        end else if (clr) begin
            for (int k = 0; k < LAG; k++) hist_r[k] <= '0;
        end else if (en) begin
            hist_r[0] <= din;
            for (int k = 1; k < LAG; k++) hist_r[k] <= hist_r[k-1];
        end
    end

    assign last = hist_r[LAG-1];

endmodule

// File: rtl/d_term_lag.sv
// Derivative term: D_term = d_coeff * sat(err_sat - err(n-LAG)), registered
// with a one-cycle valid strobe. Optional macro D_WARMUP_EN holds the output
// at zero until LAG samples have filled the history.
module d_term_lag
    import d_term_pkg::*;
#(
    parameter  int ERR_W   = D_ERR_W,
    parameter  int DIFF_W  = D_DIFF_W,
    parameter  int COEFF_W = D_COEFF_W,
    parameter  int LAG     = D_LAG_DFLT,
    localparam int OUT_W   = DIFF_W + COEFF_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [ERR_W-1:0]   err_sat,
    input  logic               err_vld,
    input  logic [COEFF_W-1:0] d_coeff,
    input  logic               clr,
    output logic [OUT_W-1:0]   D_term,
    output logic               D_vld,
    output logic               D_sat
);

    logic [ERR_W-1:0]          hist_last_s;
    logic signed [ERR_W:0]     diff_s;
    sat_res_t                  sat_s;
    logic signed [DIFF_W-1:0]  diff_sat_s;
    logic signed [COEFF_W:0]   coeff_ext_s;
    logic signed [OUT_W-1:0]   prod_s;
    logic                      warm_s;

    d_hist_shift #(
        .ERR_W (ERR_W),
        .LAG   (LAG)
    ) u_hist (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .en    (err_vld),
        .din   (err_sat),
        .last  (hist_last_s)
    );

    // Difference one bit wider than the inputs so it cannot wrap, then clamp and scale.
    always_comb begin
        diff_s      = $signed({err_sat[ERR_W-1], err_sat}) - $signed({hist_last_s[ERR_W-1], hist_last_s});
        sat_s       = sat_signed(32'(diff_s), DIFF_W);
        diff_sat_s  = DIFF_W'(sat_s.value);
        coeff_ext_s = $signed({1'b0, d_coeff});
        prod_s      = OUT_W'(coeff_ext_s) * OUT_W'(diff_sat_s);
    end

`ifdef D_WARMUP_EN
    localparam int FILL_W = $clog2(LAG + 1);
    localparam logic [FILL_W-1:0] LAG_F = FILL_W'(LAG);

    logic [FILL_W-1:0] fill_r;

    // Count accepted samples up to LAG so the start-up kick can be masked.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fill_r <= '0;
        end else if (clr) begin
            fill_r <= '0;
        end else if (err_vld && (fill_r < LAG_F)) begin
            fill_r <= fill_r + FILL_W'(1);
        end
    end

    assign warm_s = (fill_r < LAG_F);
`else
    assign warm_s = 1'b0;
`endif

    // Output register: update on each accepted sample, hold otherwise, clear wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            D_term <= '0;
            D_sat  <= 1'b0;
            D_vld  <= 1'b0;
        end else if (clr) begin
            D_term <= '0;
            D_sat  <= 1'b0;
            D_vld  <= 1'b0;
        end else if (err_vld) begin
            D_vld <= 1'b1;
            if (warm_s) begin
                D_term <= '0;
                D_sat  <= 1'b0;
            end else begin
                D_term <= prod_s;
                D_sat  <= sat_s.sat;
            end
        end else begin
            D_vld <= 1'b0;
        end
    end

endmodule

// File: tb/tb_d_term_lag.sv
// Directed self-checking bench for d_term_lag. With D_WARMUP_EN defined the
// bench builds LAG=3 and runs the warm-up scenario instead of the default set.
module tb_d_term_lag;

    localparam int ERR_W   = 10;
    localparam int DIFF_W  = 7;
    localparam int COEFF_W = 6;
    localparam int OUT_W   = DIFF_W + COEFF_W;
`ifdef D_WARMUP_EN
    localparam int LAG = 3;
`else
    localparam int LAG = 2;
`endif

    logic               clk;
    logic               rst_n;
    logic [ERR_W-1:0]   err_sat;
    logic               err_vld;
    logic [COEFF_W-1:0] d_coeff;
    logic               clr;
    logic [OUT_W-1:0]   D_term;
    logic               D_vld;
    logic               D_sat;

    int vectors;
    int miscompares;

    d_term_lag #(
        .ERR_W   (ERR_W),
        .DIFF_W  (DIFF_W),
        .COEFF_W (COEFF_W),
        .LAG     (LAG)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .err_sat (err_sat),
        .err_vld (err_vld),
        .d_coeff (d_coeff),
        .clr     (clr),
        .D_term  (D_term),
        .D_vld   (D_vld),
        .D_sat   (D_sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one valid sample; returns 1 time unit after the capturing edge.
    task automatic send(input int e, input int c);
        @(negedge clk);
        err_sat = ERR_W'(e);
        d_coeff = COEFF_W'(c);
        err_vld = 1'b1;
        @(posedge clk);
        #1;
        err_vld = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_clr();
        @(negedge clk);
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
    endtask

    task automatic test_reset();
        vectors++;
        if (D_term !== 13'd0 || D_vld !== 1'b0 || D_sat !== 1'b0) begin
            miscompares++;
            $display("FAIL reset: got term=%0d vld=%b sat=%b want 0/0/0", $signed(D_term), D_vld, D_sat);
        end
    endtask

`ifndef D_WARMUP_EN
    task automatic test_kick();
        int exp_t [3] = '{0, 0, 693};
        bit exp_s [3] = '{1'b0, 1'b0, 1'b1};
        int errs  [3] = '{0, 0, 100};
        for (int i = 0; i < 3; i++) begin
            send(errs[i], 11);
            vectors++;
            if (D_vld !== 1'b1 || $signed(D_term) !== 13'(exp_t[i]) || D_sat !== exp_s[i]) begin
                miscompares++;
                $display("FAIL kick[%0d]: got term=%0d vld=%b sat=%b want %0d/1/%b", i, $signed(D_term), D_vld, D_sat, exp_t[i], exp_s[i]);
            end
        end
        idle(1);
        vectors++;
        if (D_vld !== 1'b0 || $signed(D_term) !== 13'(693) || D_sat !== 1'b1) begin
            miscompares++;
            $display("FAIL kick_hold: got term=%0d vld=%b sat=%b want 693/0/1", $signed(D_term), D_vld, D_sat);
        end
    endtask

    task automatic test_ramp();
        int errs [4] = '{10, 20, 30, 40};
        int exp_t [4] = '{110, 220, 220, 220};
        do_clr();
        for (int i = 0; i < 4; i++) begin
            send(errs[i], 11);
            vectors++;
            if (D_vld !== 1'b1 || $signed(D_term) !== 13'(exp_t[i]) || D_sat !== 1'b0) begin
                miscompares++;
                $display("FAIL ramp[%0d]: got term=%0d vld=%b sat=%b want %0d/1/0", i, $signed(D_term), D_vld, D_sat, exp_t[i]);
            end
            idle(i + 1);
            vectors++;
            if (D_vld !== 1'b0 || $signed(D_term) !== 13'(exp_t[i])) begin
                miscompares++;
                $display("FAIL ramp_gap[%0d]: got term=%0d vld=%b want %0d/0", i, $signed(D_term), D_vld, exp_t[i]);
            end
        end
    endtask

    task automatic test_neg_sat();
        int errs [4] = '{-100, -100, -300, -300};
        do_clr();
        for (int i = 0; i < 4; i++) begin
            send(errs[i], 11);
            vectors++;
            if (D_vld !== 1'b1 || $signed(D_term) !== 13'(-704) || D_sat !== 1'b1) begin
                miscompares++;
                $display("FAIL neg_sat[%0d]: got term=%0d vld=%b sat=%b want -704/1/1", i, $signed(D_term), D_vld, D_sat);
            end
        end
    endtask

    task automatic test_clr_collision();
        @(negedge clk);
        err_sat = ERR_W'(50);
        d_coeff = COEFF_W'(11);
        err_vld = 1'b1;
        clr     = 1'b1;
        @(posedge clk);
        #1;
        err_vld = 1'b0;
        clr     = 1'b0;
        vectors++;
        if (D_vld !== 1'b0 || D_term !== 13'd0 || D_sat !== 1'b0) begin
            miscompares++;
            $display("FAIL clr_collide: got term=%0d vld=%b sat=%b want 0/0/0", $signed(D_term), D_vld, D_sat);
        end
        send(5, 11);
        vectors++;
        if (D_vld !== 1'b1 || $signed(D_term) !== 13'(55) || D_sat !== 1'b0) begin
            miscompares++;
            $display("FAIL clr_after: got term=%0d vld=%b sat=%b want 55/1/0", $signed(D_term), D_vld, D_sat);
        end
    endtask

    task automatic test_coeff();
        do_clr();
        send(10, 0);
        vectors++;
        if ($signed(D_term) !== 13'(0) || D_sat !== 1'b0) begin
            miscompares++;
            $display("FAIL coeff0_nosat: got term=%0d sat=%b want 0/0", $signed(D_term), D_sat);
        end
        send(100, 0);
        vectors++;
        if ($signed(D_term) !== 13'(0) || D_sat !== 1'b1) begin
            miscompares++;
            $display("FAIL coeff0_sat: got term=%0d sat=%b want 0/1", $signed(D_term), D_sat);
        end
        do_clr();
        send(-64, 63);
        vectors++;
        if ($signed(D_term) !== 13'(-4032) || D_sat !== 1'b0) begin
            miscompares++;
            $display("FAIL coeff63: got term=%0d sat=%b want -4032/0", $signed(D_term), D_sat);
        end
        d_coeff = COEFF_W'(5);
        idle(2);
        d_coeff = COEFF_W'(33);
        idle(1);
        vectors++;
        if ($signed(D_term) !== 13'(-4032)) begin
            miscompares++;
            $display("FAIL coeff_toggle_hold: got term=%0d want -4032", $signed(D_term));
        end
        send(-64, 7);
        vectors++;
        if ($signed(D_term) !== 13'(-448) || D_sat !== 1'b0) begin
            miscompares++;
            $display("FAIL coeff_sampled: got term=%0d sat=%b want -448/0", $signed(D_term), D_sat);
        end
    endtask

    task automatic test_async_reset();
        send(30, 11);
        send(40, 11);
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (D_term !== 13'd0 || D_vld !== 1'b0 || D_sat !== 1'b0) begin
            miscompares++;
            $display("FAIL async_rst: got term=%0d vld=%b sat=%b want 0/0/0", $signed(D_term), D_vld, D_sat);
        end
        @(negedge clk);
        rst_n = 1'b1;
        send(5, 11);
        vectors++;
        if (D_vld !== 1'b1 || $signed(D_term) !== 13'(55) || D_sat !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_first: got term=%0d vld=%b sat=%b want 55/1/0", $signed(D_term), D_vld, D_sat);
        end
    endtask
`else
    task automatic test_warmup();
        int errs  [4] = '{5, 5, 5, 9};
        int exp_t [4] = '{0, 0, 0, 44};
        for (int i = 0; i < 4; i++) begin
            send(errs[i], 11);
            vectors++;
            if (D_vld !== 1'b1 || $signed(D_term) !== 13'(exp_t[i]) || D_sat !== 1'b0) begin
                miscompares++;
                $display("FAIL warmup[%0d]: got term=%0d vld=%b sat=%b want %0d/1/0", i, $signed(D_term), D_vld, D_sat, exp_t[i]);
            end
        end
        #2;
        rst_n = 1'b0;
        #3;
        @(negedge clk);
        rst_n = 1'b1;
        send(90, 11);
        vectors++;
        if (D_vld !== 1'b1 || $signed(D_term) !== 13'(0) || D_sat !== 1'b0) begin
            miscompares++;
            $display("FAIL warmup_restart: got term=%0d vld=%b sat=%b want 0/1/0", $signed(D_term), D_vld, D_sat);
        end
    endtask
`endif

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n   = 1'b0;
        err_sat = '0;
        err_vld = 1'b0;
        d_coeff = '0;
        clr     = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        @(negedge clk);
        rst_n = 1'b1;
        idle(1);
`ifndef D_WARMUP_EN
        test_kick();
        test_ramp();
        test_neg_sat();
        test_clr_collision();
        test_coeff();
        test_async_reset();
`else
        test_warmup();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/d_term_lag.md
Name: d_term_lag

Overview:
- Parametrised derivative-term generator for the PID datapath; next generation of the fixed 10-bit, fixed-lag D-term block.
- Keeps a history of LAG valid error samples and forms diff = err_sat − err(n−LAG).
- Saturates diff to DIFF_W bits, multiplies by a runtime coefficient, and registers the result with a valid strobe.
- Sits between the error saturator and the PID summer; adds clear, saturation flag and registered output.

Parameters:
- ERR_W, 10, width of signed input error.
- DIFF_W, 7, width of signed saturated difference.
- COEFF_W, 6, width of unsigned D coefficient.
- LAG, 2, derivative lag in err_vld samples (legal 1..16).
- OUT_W, DIFF_W+COEFF_W, width of signed product (derived; not overridden).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- err_sat  in  ERR_W  signed saturated error.
- err_vld  in  1  err_sat valid this cycle.
- d_coeff  in  COEFF_W  unsigned coefficient, sampled when err_vld=1.
- clr  in  1  synchronous flush of history and output.
- D_term  out  OUT_W  signed registered derivative term.
- D_vld  out  1  one-cycle strobe: D_term updated.
- D_sat  out  1  diff saturated for the sample now on D_term.

Behaviour:
- Reset: history[0..LAG−1]=0, D_term=0, D_vld=0, D_sat=0.
- History shift register: on err_vld, hist[0]<=err_sat and hist[k]<=hist[k−1]. hist[LAG−1] is the sample LAG valid strobes ago. Cycles with err_vld=0 do not shift.
- Difference: diff = err_sat − hist[LAG−1], computed at ERR_W+1 bits so no wrap.
- Saturation to DIFF_W signed range:
  - diff > 2^(DIFF_W−1)−1 gives 2^(DIFF_W−1)−1 (+63 at default).
  - diff < −2^(DIFF_W−1) gives −2^(DIFF_W−1) (−64 at default).
  - D_sat=1 whenever clamping occurred.
- Product: $signed({1'b0,d_coeff}) × diff_sat, truncated to OUT_W. No overflow at default widths: worst case 63×−64 = −4032.
- Latency: err_vld in cycle n gives D_term, D_sat and D_vld=1 in cycle n+1. D_vld is low on all other cycles.
- D_term and D_sat hold their value between strobes.
- clr=1 in any cycle, at the next edge:
  - history=0, D_term=0, D_sat=0, D_vld=0.
  - clr has priority over a simultaneous err_vld; that sample is discarded and does not enter the history.
- First LAG samples after reset or clr difference against zero-filled history (start-up behaviour of the previous generation).
- d_coeff changes between strobes have no effect; only the value present with err_vld is used.
- rst_n deassertion mid-stream: the first err_vld after reset behaves exactly like the first after clr.

Optional Feature:
- Macro D_WARMUP_EN.
- When defined:
  - A fill counter (clog2(LAG+1) bits, saturating at LAG) counts accepted samples; reset and clr zero it.
  - While fill<LAG, the output stage forces D_term=0 and D_sat=0. D_vld still strobes.
  - Suppresses the start-up kick from zero history.
- When undefined: no counter; zero-filled history is used as described above.

Decomposition:
- Package d_term_pkg holds:
  - defaults D_ERR_W=10, D_DIFF_W=7, D_COEFF_W=6, D_LAG_DFLT=2, D_COEFF_DFLT=6'h0B;
  - function sat_signed(value, width) returning the clamped value and a saturation flag.
- One natural sub-module: d_hist_shift (parametrised ERR_W×LAG shift register with enable and sync clear).
- Subtract, saturate, multiply and output register stay in d_term_lag.

Test Plan:
- Default params, d_coeff=11, clr held low. err_vld stream err=0,0,100 → third strobe: diff=100 saturated to 63, D_term=693, D_sat=1, D_vld exactly one cycle after err_vld.
- Stream 10,20,30,40 (LAG=2, coeff=11) → D_term = 110,220,220,220, D_sat=0. Gaps of idle cycles between strobes leave results unchanged.
- History holding −100,−100, then err=−300 → diff=−200 clamps to −64, D_term=−704, D_sat=1. Then err=−300 against hist −100 again → −704.
- clr asserted in the same cycle as err_vld=1 (err=50) → D_vld=0, D_term=0. Next err_vld with err=5 → D_term=55 (history was zero).
- d_coeff=0 → D_term=0 with correct D_sat. d_coeff=63 with diff=−64 → −4032. Coefficient toggled between strobes has no effect.
- D_WARMUP_EN defined, LAG=3, coeff=11, stream 5,5,5,9 → first three outputs 0 with D_vld pulsing, fourth D_term=44. Async rst_n pulse then restarts warm-up.
